exec_controller: RTL and testbench

EXEC_CONTROLLER -- requirements
Module: exec_controller

---
 rtl/exec_controller.sv | 127 ++++++++++++
 tb/tb_exec_controller.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// Run/halt/step/breakpoint execution controller with saturating cycle counter.
// Define EXEC_CTRL_BREAKPOINT_EN to build the breakpoint logic and BRK state.
module exec_controller #(
    parameter int I_ADDR_W = 12,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_req,
    input  logic                halt_req,
    input  logic                step_req,
    input  logic                halt_instr,
    input  logic [I_ADDR_W-1:0] pc,
    input  logic [I_ADDR_W-1:0] bp_addr,
    input  logic                bp_valid,
    input  logic                clr_count,
    output logic                cpu_en,
    output logic [1:0]          state,
    output logic [1:0]          stop_cause,
    output logic                step_done,
    output logic [COUNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        S_HALTED = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_BRK    = 2'd3
    } state_t;

    localparam logic [1:0] C_REQ  = 2'd0;
    localparam logic [1:0] C_HALT = 2'd1;
    localparam logic [1:0] C_BP   = 2'd2;
    localparam logic [1:0] C_STEP = 2'd3;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_cause;
    logic [1:0]           w_cause_nxt;
    logic                 r_step_done;
    logic                 r_bp_skip;
    logic                 w_bp_skip_nxt;
    logic                 w_bp_hit;
    logic [COUNT_W-1:0]   r_count;

`ifdef EXEC_CTRL_BREAKPOINT_EN
    assign w_bp_hit = bp_valid && (pc == bp_addr) && !r_bp_skip;
`else
    logic w_unused;
    assign w_bp_hit = 1'b0;
    assign w_unused = &{1'b0, bp_valid, bp_addr, pc};
`endif

    always_comb begin
        cpu_en = ((r_state == S_RUN) && !w_bp_hit) || (r_state == S_STEP);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cause_nxt   = r_cause;
        // Skip is held until the resumed instruction actually executes
        w_bp_skip_nxt = cpu_en ? 1'b0 : r_bp_skip;
        unique case (r_state)
            S_HALTED, S_BRK: begin
                if (halt_req) begin
                    w_state_nxt = S_HALTED;
                    if (r_state == S_BRK) w_cause_nxt = C_REQ;
                end else if (step_req) begin
                    w_state_nxt   = S_STEP;
                    w_bp_skip_nxt = 1'b1;
                end else if (run_req) begin
                    w_state_nxt   = S_RUN;
                    w_bp_skip_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (cpu_en && halt_instr) begin
                    w_state_nxt = S_HALTED;
                    w_cause_nxt = C_HALT;
                end else if (halt_req) begin
                    w_state_nxt = S_HALTED;
                    w_cause_nxt = C_REQ;
                end else if (w_bp_hit) begin
                    w_state_nxt = S_BRK;
                    w_cause_nxt = C_BP;
                end
            end
            S_STEP: begin
                w_state_nxt = S_HALTED;
                w_cause_nxt = halt_instr ? C_HALT : C_STEP;
            end
            default: begin
                w_state_nxt = S_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_HALTED;
            r_cause     <= C_REQ;
            r_step_done <= 1'b0;
            r_bp_skip   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cause     <= w_cause_nxt;
            r_step_done <= (r_state == S_STEP);
            r_bp_skip   <= w_bp_skip_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr_count) begin
            r_count <= '0;
        end else if (cpu_en && (r_count != {COUNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign state       = r_state;
    assign stop_cause  = r_cause;
    assign step_done   = r_step_done;
    assign cycle_count = r_count;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: directed scenarios plus
// randomized traffic against a rule-level reference model.
module tb_exec_controller;

`ifdef EXEC_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        halt_instr = 1'b0;
    logic [11:0] pc = '0;
    logic [11:0] bp_addr = '0;
    logic        bp_valid = 1'b0;
    logic        clr_count = 1'b0;
    logic        cpu_en;
    logic [1:0]  state;
    logic [1:0]  stop_cause;
    logic        step_done;
    logic [15:0] cycle_count;
    logic        s_cpu_en;
    logic [1:0]  s_state;
    logic [1:0]  s_stop_cause;
    logic        s_step_done;
    logic [3:0]  s_count;

    int checks = 0;
    int failures = 0;

    // Reference model (0 HALTED, 1 RUN, 2 STEP, 3 BRK)
    int m_st, m_cause, m_cnt, m_cnt4;
    bit m_done, m_skip;

    always #5 clk = ~clk;

    exec_controller u_dut (
        .clk(clk), .reset(reset), .run_req(run_req),
        .halt_req(halt_req), .step_req(step_req),
        .halt_instr(halt_instr), .pc(pc), .bp_addr(bp_addr),
        .bp_valid(bp_valid), .clr_count(clr_count),
        .cpu_en(cpu_en), .state(state), .stop_cause(stop_cause),
        .step_done(step_done), .cycle_count(cycle_count)
    );

    exec_controller #(.I_ADDR_W(12), .COUNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .run_req(run_req),
        .halt_req(halt_req), .step_req(step_req),
        .halt_instr(halt_instr), .pc(pc), .bp_addr(bp_addr),
        .bp_valid(bp_valid), .clr_count(clr_count),
        .cpu_en(s_cpu_en), .state(s_state),
        .stop_cause(s_stop_cause), .step_done(s_step_done),
        .cycle_count(s_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_hit();
        return BP_EN && bp_valid && (pc == bp_addr) && !m_skip;
    endfunction

    function automatic bit m_en();
        return (m_st == 1 && !m_hit()) || m_st == 2;
    endfunction

    task automatic m_reset();
        m_st = 0; m_cause = 0; m_done = 0; m_skip = 0;
        m_cnt = 0; m_cnt4 = 0;
    endtask

    // Advance one edge: evaluate the rules on current inputs, then clock
    task automatic tick();
        int nst, nc, nk, n16, n4;
        bit en, hit, nd;
        en = m_en(); hit = m_hit();
        nst = m_st; nc = m_cause; nd = (m_st == 2);
        nk = en ? 0 : int'(m_skip);
        if (m_st == 0 || m_st == 3) begin
            if (halt_req) begin
                nst = 0;
                if (m_st == 3) nc = 0;
            end else if (step_req) begin
                nst = 2; nk = 1;
            end else if (run_req) begin
                nst = 1; nk = 1;
            end
        end else if (m_st == 1) begin
            if (en && halt_instr) begin nst = 0; nc = 1; end
            else if (halt_req) begin nst = 0; nc = 0; end
            else if (hit) begin nst = 3; nc = 2; end
        end else begin
            nst = 0; nc = halt_instr ? 1 : 3;
        end
        n16 = clr_count ? 0 : (en ? ((m_cnt < 65535) ? m_cnt + 1 : m_cnt) : m_cnt);
        n4 = clr_count ? 0 : (en ? ((m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4) : m_cnt4);
        @(posedge clk);
        if (reset) m_reset();
        else begin
            m_st = nst; m_cause = nc; m_done = nd; m_skip = nk[0];
            m_cnt = n16; m_cnt4 = n4;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run_req = 0; halt_req = 0; step_req = 0;
        halt_instr = 0; clr_count = 0; bp_valid = 0; pc = '0;
        tick();
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        m_reset();
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        checks++;
        if (cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_cpu_en: got %b want 0", cpu_en);
        end
        checks++;
        if (stop_cause !== 2'd0 || step_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_cause_done: got %0d/%b want 0/0",
                     stop_cause, step_done);
        end
        checks++;
        if (cycle_count !== 16'd0 || s_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d/%0d want 0/0",
                     cycle_count, s_count);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_step();
        int pulses, dones;
        pulses = 0; dones = 0;
        for (int k = 0; k < 3; k++) begin
            pc = 12'(2 * k);
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            #1;
            checks++;
            if (state !== 2'd2 || cpu_en !== 1'b1) begin
                failures++;
                $display("FAIL step_enter: got st=%0d en=%b want 2/1",
                         state, cpu_en);
            end
            pulses += int'(cpu_en);
            tick();
            pulses += int'(cpu_en);
            dones += int'(step_done);
            checks++;
            if (state !== 2'd0 || step_done !== 1'b1 || cpu_en !== 1'b0) begin
                failures++;
                $display("FAIL step_exit: got st=%0d done=%b en=%b want 0/1/0",
                         state, step_done, cpu_en);
            end
        end
        tick();
        dones += int'(step_done);
        checks++;
        if (pulses != 3 || dones != 3) begin
            failures++;
            $display("FAIL step_pulses: got en=%0d done=%0d want 3/3",
                     pulses, dones);
        end
        checks++;
        if (cycle_count !== 16'd3 || stop_cause !== 2'd3) begin
            failures++;
            $display("FAIL step_final: got cnt=%0d cause=%0d want 3/3",
                     cycle_count, stop_cause);
        end
    endtask

    task automatic test_halt_instr();
        do_reset();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            pc = 12'(2 * i);
            halt_instr = (i == 10);
            #1;
            checks++;
            if (cpu_en !== 1'b1) begin
                failures++;
                $display("FAIL run_en cycle %0d: got %b want 1", i, cpu_en);
            end
            tick();
        end
        halt_instr = 1'b0;
        checks++;
        if (state !== 2'd0 || stop_cause !== 2'd1 || cycle_count !== 16'd10) begin
            failures++;
            $display("FAIL halt_instr: got st=%0d cause=%0d cnt=%0d want 0/1/10",
                     state, stop_cause, cycle_count);
        end
    endtask

    task automatic test_breakpoint();
        logic exp_en;
        logic [1:0] exp_st;
        do_reset();
        bp_valid = 1'b1; bp_addr = 12'h008; pc = 12'h000;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int p = 0; p < 8; p += 2) begin
            pc = 12'(p);
            tick();
        end
        pc = 12'h008;
        #1;
        exp_en = BP_EN ? 1'b0 : 1'b1;
        checks++;
        if (cpu_en !== exp_en) begin
            failures++;
            $display("FAIL bp_en_at_hit: got %b want %b", cpu_en, exp_en);
        end
        tick();
        exp_st = BP_EN ? 2'd3 : 2'd1;
        checks++;
        if (state !== exp_st || stop_cause !== 2'(m_cause)) begin
            failures++;
            $display("FAIL bp_state: got st=%0d cause=%0d want %0d/%0d",
                     state, stop_cause, exp_st, m_cause);
        end
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        #1;
        checks++;
        if (state !== 2'd1 || cpu_en !== 1'b1) begin
            failures++;
            $display("FAIL bp_resume: got st=%0d en=%b want 1/1",
                     state, cpu_en);
        end
        tick();
        pc = 12'h00a;
        tick();
        checks++;
        if (state !== 2'd1 || cycle_count !== 16'(m_cnt)) begin
            failures++;
            $display("FAIL bp_continue: got st=%0d cnt=%0d want 1/%0d",
                     state, cycle_count, m_cnt);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        bp_valid = 1'b0;
    endtask

    task automatic test_halt_vs_bp();
        logic exp_en;
        do_reset();
        bp_valid = 1'b1; bp_addr = 12'h004; pc = 12'h000;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        pc = 12'h002;
        tick();
        pc = 12'h004;
        halt_req = 1'b1;
        #1;
        exp_en = BP_EN ? 1'b0 : 1'b1;
        checks++;
        if (cpu_en !== exp_en) begin
            failures++;
            $display("FAIL hvb_en: got %b want %b", cpu_en, exp_en);
        end
        tick();
        halt_req = 1'b0;
        bp_valid = 1'b0;
        checks++;
        if (state !== 2'd0 || stop_cause !== 2'd0) begin
            failures++;
            $display("FAIL hvb_state: got st=%0d cause=%0d want 0/0",
                     state, stop_cause);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pc = 12'($urandom_range(0, 4095));
            tick();
        end
        checks++;
        if (s_count !== 4'd15 || cycle_count !== 16'd20) begin
            failures++;
            $display("FAIL saturate: got %0d/%0d want 15/20",
                     s_count, cycle_count);
        end
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        checks++;
        if (s_count !== 4'd0 || cycle_count !== 16'd0) begin
            failures++;
            $display("FAIL clr_count: got %0d/%0d want 0/0",
                     s_count, cycle_count);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick(); tick();
        #3;
        reset = 1'b1;
        #1;
        m_reset();
        checks++;
        if (cpu_en !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("FAIL async_run: got en=%b st=%0d want 0/0",
                     cpu_en, state);
        end
        tick();
        reset = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        m_reset();
        checks++;
        if (state !== 2'd0 || cpu_en !== 1'b0 || step_done !== 1'b0) begin
            failures++;
            $display("FAIL async_step: got st=%0d en=%b done=%b want 0/0/0",
                     state, cpu_en, step_done);
        end
        tick();
        checks++;
        if (step_done !== 1'b0) begin
            failures++;
            $display("FAIL async_no_done: got %b want 0", step_done);
        end
        reset = 1'b0;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL release_run: got %0d want 1", state);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
    endtask

    task automatic test_random();
        logic exp_en;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            run_req    = ($urandom_range(0, 5) == 0);
            halt_req   = ($urandom_range(0, 11) == 0);
            step_req   = ($urandom_range(0, 6) == 0);
            halt_instr = ($urandom_range(0, 14) == 0);
            clr_count  = ($urandom_range(0, 39) == 0);
            bp_valid   = ($urandom_range(0, 1) == 1);
            bp_addr    = 12'(2 * $urandom_range(0, 3));
            pc         = 12'(2 * $urandom_range(0, 3));
            #1;
            exp_en = reset ? 1'b0 : m_en();
            checks++;
            if (cpu_en !== exp_en || s_cpu_en !== exp_en) begin
                failures++;
                $display("FAIL rand_en[%0d]: got %b/%b want %b",
                         i, cpu_en, s_cpu_en, exp_en);
            end
            tick();
            checks++;
            if (state !== 2'(m_st) || stop_cause !== 2'(m_cause) ||
                step_done !== m_done) begin
                failures++;
                $display("FAIL rand_ctl[%0d]: got %0d/%0d/%b want %0d/%0d/%b",
                         i, state, stop_cause, step_done,
                         m_st, m_cause, m_done);
            end
            checks++;
            if (cycle_count !== 16'(m_cnt) || s_count !== 4'(m_cnt4)) begin
                failures++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d",
                         i, cycle_count, s_count, m_cnt, m_cnt4);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_step();
        test_halt_instr();
        test_breakpoint();
        test_halt_vs_bp();
        test_saturate();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
